// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl
//  Description : MEM-stage sequencing controller for the pipelined LC-3b.
//                Owns the data-memory port and issues LDR/LDB/STR/STB
//                accesses. LDI/STI run a pointer fetch before the data
//                access. Drives the pipeline stall and the WB load enable.
//                Optional response timeout is enabled by defining
//                LC3B_MEM_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_is_load,
  input  logic        mem_is_store,
  input  logic        mem_is_indirect,
  input  logic        mem_is_byte,
  input  logic [15:0] mem_address,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [1:0]  dmem_byte_en,
  output logic        pipe_stall,
  output logic        load_wb,
  output logic [15:0] mem_rdata_out,
  output logic        timeout_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_IND  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Reject out-of-range timeout settings at elaboration time.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_stage_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  logic [1:0]  state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] rdata_q, rdata_d;
  logic        w_is_mem;
  logic [15:0] w_base;

  assign w_is_mem = mem_valid & (mem_is_load | mem_is_store);

`ifdef LC3B_MEM_TIMEOUT_EN
  // Counter value seen on the last cycle allowed to wait for a response.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;
  logic       w_expired;

  assign w_expired = (wait_cnt_q == TIMEOUT_LAST);
`endif

  // The second access of LDI/STI uses the fetched pointer as its address.
  assign w_base = (state_q == ST_ACC && mem_is_indirect) ? ptr_q : mem_address;

  // Moore request outputs, driven only while an access is outstanding.
  always_comb begin
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_address = 16'h0000;
    dmem_byte_en = 2'b00;
    case (state_q)
      ST_IND: begin
        dmem_read    = 1'b1;
        dmem_address = {mem_address[15:1], 1'b0};
        dmem_byte_en = 2'b11;
      end
      ST_ACC: begin
        dmem_read    = mem_is_load;
        // Load wins if both flags are set, so no write is issued.
        dmem_write   = mem_is_store & ~mem_is_load;
        dmem_address = {w_base[15:1], 1'b0};
        if (mem_is_byte && !mem_is_indirect) begin
          dmem_byte_en = w_base[0] ? 2'b10 : 2'b01;
        end else begin
          dmem_byte_en = 2'b11;
        end
      end
      default: begin
      end
    endcase
  end

  // Stall covers the issuing IDLE cycle and every cycle spent waiting.
  always_comb begin
    pipe_stall = 1'b0;
    case (state_q)
      ST_IDLE: pipe_stall = w_is_mem;
      ST_IND:  pipe_stall = 1'b1;
      ST_ACC:  pipe_stall = 1'b1;
      default: pipe_stall = 1'b0;
    endcase
  end

  assign load_wb       = ~pipe_stall;
  assign mem_rdata_out = rdata_q;

  // Next-state, pointer and load-data capture logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rdata_d = rdata_q;
`ifdef LC3B_MEM_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_is_mem) begin
          state_d = mem_is_indirect ? ST_IND : ST_ACC;
`ifdef LC3B_MEM_TIMEOUT_EN
          wait_cnt_d = 8'd0;
`endif
        end
      end
      ST_IND: begin
        if (dmem_resp) begin
          ptr_d   = dmem_rdata;
          state_d = ST_ACC;
`ifdef LC3B_MEM_TIMEOUT_EN
          wait_cnt_d = 8'd0;
        end else if (w_expired) begin
          // Abandon the pointer fetch; the data access never happens.
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          if (mem_is_load) begin
            rdata_d = 16'h0000;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
`endif
        end
      end
      ST_ACC: begin
        if (dmem_resp) begin
          state_d = ST_DONE;
          if (mem_is_load) begin
            rdata_d = dmem_rdata;
          end
`ifdef LC3B_MEM_TIMEOUT_EN
        end else if (w_expired) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          if (mem_is_load) begin
            rdata_d = 16'h0000;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef LC3B_MEM_TIMEOUT_EN
  // Wait counter and abort flag; the flag is high only during DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_ctrl
//  Description : Directed, table-driven bench for mem_stage_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_is_load, mem_is_store, mem_is_indirect, mem_is_byte;
  logic [15:0] mem_address, dmem_rdata;
  logic        dmem_resp;
  logic        dmem_read, dmem_write, pipe_stall, load_wb, timeout_err;
  logic [15:0] dmem_address, mem_rdata_out;
  logic [1:0]  dmem_byte_en;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_valid       (mem_valid),
    .mem_is_load     (mem_is_load),
    .mem_is_store    (mem_is_store),
    .mem_is_indirect (mem_is_indirect),
    .mem_is_byte     (mem_is_byte),
    .mem_address     (mem_address),
    .dmem_rdata      (dmem_rdata),
    .dmem_resp       (dmem_resp),
    .dmem_read       (dmem_read),
    .dmem_write      (dmem_write),
    .dmem_address    (dmem_address),
    .dmem_byte_en    (dmem_byte_en),
    .pipe_stall      (pipe_stall),
    .load_wb         (load_wb),
    .mem_rdata_out   (mem_rdata_out),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic        by;
    logic [15:0] addr;
    logic [15:0] rdata;
    int          k;
    logic [15:0] e_addr;
    logic [1:0]  e_ben;
    logic        e_rd;
    logic        e_wr;
    logic [15:0] e_out;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_is_load = 1'b0; mem_is_store = 1'b0;
    mem_is_indirect = 1'b0; mem_is_byte = 1'b0;
    dmem_resp = 1'b0;
  endtask

  // Direct access: one IDLE issue cycle, k ACC cycles, then DONE.
  task automatic run_vec(input vec_t v, input int idx);
    int stalls;
    mem_valid = 1'b1; mem_is_load = v.ld; mem_is_store = v.st;
    mem_is_indirect = 1'b0; mem_is_byte = v.by; mem_address = v.addr;
    #3;
    chk($sformatf("v%0d idle_stall", idx), {31'd0, pipe_stall}, 32'd1);
    stalls = pipe_stall ? 1 : 0;
    for (int c = 1; c <= v.k; c++) begin
      tick();
      dmem_resp  = (c == v.k);
      dmem_rdata = (c == v.k) ? v.rdata : 16'hDEAD;
      #3;
      chk($sformatf("v%0d read", idx),  {31'd0, dmem_read},  {31'd0, v.e_rd});
      chk($sformatf("v%0d write", idx), {31'd0, dmem_write}, {31'd0, v.e_wr});
      chk($sformatf("v%0d addr", idx),  {16'd0, dmem_address}, {16'd0, v.e_addr});
      chk($sformatf("v%0d ben", idx),   {30'd0, dmem_byte_en}, {30'd0, v.e_ben});
      if (pipe_stall) stalls++;
    end
    tick();
    idle_inputs();
    #3;
    chk($sformatf("v%0d stall_cycles", idx), stalls, 1 + v.k);
    chk($sformatf("v%0d done_load_wb", idx), {31'd0, load_wb}, 32'd1);
    chk($sformatf("v%0d done_read", idx), {31'd0, dmem_read | dmem_write}, 32'd0);
    chk($sformatf("v%0d rdata_out", idx), {16'd0, mem_rdata_out}, {16'd0, v.e_out});
    chk($sformatf("v%0d timeout", idx), {31'd0, timeout_err}, 32'd0);
    tick();
  endtask

  initial begin
    //            ld    st    by    addr      rdata   k  e_addr    ben    rd    wr    e_out
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h3001, 16'hBEEF, 2, 16'h3000, 2'b11, 1'b1, 1'b0, 16'hBEEF};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 16'h4005, 16'h7777, 1, 16'h4004, 2'b10, 1'b0, 1'b1, 16'hBEEF};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 16'h6000, 16'h00AB, 1, 16'h6000, 2'b01, 1'b1, 1'b0, 16'h00AB};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 16'h7FFF, 16'h1111, 3, 16'h7FFE, 2'b11, 1'b0, 1'b1, 16'h00AB};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 16'h1234, 16'h5A5A, 1, 16'h1234, 2'b11, 1'b1, 1'b0, 16'h5A5A};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1, 16'hFFFE, 2'b11, 1'b1, 1'b0, 16'h0001};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 16'h0100, 16'hCAFE, 1, 16'h0100, 2'b11, 1'b1, 1'b0, 16'hCAFE};

    reset = 1'b1;
    idle_inputs();
    mem_address = 16'h0000;
    dmem_rdata  = 16'h0000;
    tick(); tick();
    #3;
    chk("rst read",    {31'd0, dmem_read},  32'd0);
    chk("rst write",   {31'd0, dmem_write}, 32'd0);
    chk("rst addr",    {16'd0, dmem_address}, 32'd0);
    chk("rst ben",     {30'd0, dmem_byte_en}, 32'd0);
    chk("rst rdata",   {16'd0, mem_rdata_out}, 32'd0);
    chk("rst timeout", {31'd0, timeout_err}, 32'd0);
    chk("rst load_wb", {31'd0, load_wb}, 32'd1);
    tick();
    reset = 1'b0;
    tick();

    // Non-memory instruction: no stall, WB loads in the same cycle.
    mem_valid = 1'b1; mem_address = 16'h2222;
    #3;
    chk("nonmem stall",   {31'd0, pipe_stall}, 32'd0);
    chk("nonmem load_wb", {31'd0, load_wb}, 32'd1);
    chk("nonmem req",     {31'd0, dmem_read | dmem_write}, 32'd0);
    tick();
    #3;
    chk("nonmem stays idle", {31'd0, dmem_read | pipe_stall}, 32'd0);
    idle_inputs();
    tick();

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // LDI 0x2000 -> pointer 0x5002 -> data 0x1234, each response first cycle.
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_is_indirect = 1'b1; mem_address = 16'h2000;
    #3;
    chk("ldi idle_stall", {31'd0, pipe_stall}, 32'd1);
    tick();
    dmem_resp = 1'b1; dmem_rdata = 16'h5002;
    #3;
    chk("ldi ind read",  {31'd0, dmem_read}, 32'd1);
    chk("ldi ind addr",  {16'd0, dmem_address}, 32'h2000);
    chk("ldi ind ben",   {30'd0, dmem_byte_en}, 32'd3);
    chk("ldi ind stall", {31'd0, pipe_stall}, 32'd1);
    tick();
    dmem_rdata = 16'h1234;
    #3;
    chk("ldi acc read",  {31'd0, dmem_read}, 32'd1);
    chk("ldi acc addr",  {16'd0, dmem_address}, 32'h5002);
    chk("ldi acc stall", {31'd0, pipe_stall}, 32'd1);
    tick();
    idle_inputs();
    #3;
    chk("ldi done load_wb", {31'd0, load_wb}, 32'd1);
    chk("ldi rdata_out", {16'd0, mem_rdata_out}, 32'h1234);
    tick();

    // STI byte at 0x2001: both accesses are word-wide.
    mem_valid = 1'b1; mem_is_store = 1'b1; mem_is_indirect = 1'b1; mem_is_byte = 1'b1;
    mem_address = 16'h2001;
    tick();
    dmem_resp = 1'b1; dmem_rdata = 16'h5003;
    #3;
    chk("sti ind addr", {16'd0, dmem_address}, 32'h2000);
    chk("sti ind read", {31'd0, dmem_read}, 32'd1);
    tick();
    dmem_rdata = 16'h9999;
    #3;
    chk("sti acc write", {31'd0, dmem_write}, 32'd1);
    chk("sti acc read",  {31'd0, dmem_read}, 32'd0);
    chk("sti acc addr",  {16'd0, dmem_address}, 32'h5002);
    chk("sti acc ben",   {30'd0, dmem_byte_en}, 32'd3);
    tick();
    idle_inputs();
    #3;
    chk("sti rdata_out kept", {16'd0, mem_rdata_out}, 32'h1234);
    tick();

    // Stray response in IDLE is ignored.
    dmem_resp = 1'b1; dmem_rdata = 16'hAAAA;
    tick();
    dmem_resp = 1'b0;
    #3;
    chk("idle resp read",  {31'd0, dmem_read}, 32'd0);
    chk("idle resp rdata", {16'd0, mem_rdata_out}, 32'h1234);
    tick();

    // Reset during ACC of a pending load.
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_address = 16'h8000;
    tick();
    #3;
    chk("rstacc read before", {31'd0, dmem_read}, 32'd1);
    tick();
    reset = 1'b1; mem_valid = 1'b0; mem_is_load = 1'b0;
    tick();
    reset = 1'b0;
    #3;
    chk("rstacc read",  {31'd0, dmem_read}, 32'd0);
    chk("rstacc stall", {31'd0, pipe_stall}, 32'd0);
    chk("rstacc rdata", {16'd0, mem_rdata_out}, 32'd0);
    tick();
    dmem_resp = 1'b1; dmem_rdata = 16'hFFFF;
    tick();
    dmem_resp = 1'b0;
    #3;
    chk("rstacc late resp rdata", {16'd0, mem_rdata_out}, 32'd0);
    chk("rstacc late resp read",  {31'd0, dmem_read}, 32'd0);
    tick();

    run_vec(tbl[6], 6);

`ifdef LC3B_MEM_TIMEOUT_EN
    // LDR without response: four ACC cycles, then an aborting DONE.
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_address = 16'h0101;
    for (int c = 1; c <= 4; c++) begin
      tick();
      #3;
      chk($sformatf("to acc%0d read", c), {31'd0, dmem_read}, 32'd1);
      chk($sformatf("to acc%0d err", c),  {31'd0, timeout_err}, 32'd0);
    end
    tick();
    idle_inputs();
    #3;
    chk("to done err",   {31'd0, timeout_err}, 32'd1);
    chk("to done rdata", {16'd0, mem_rdata_out}, 32'd0);
    chk("to done read",  {31'd0, dmem_read}, 32'd0);
    tick();
    #3;
    chk("to idle err", {31'd0, timeout_err}, 32'd0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencing controller for the MEM stage of the pipelined LC-3b. It owns the data-memory port and issues reads and writes for LDR/LDB/STR/STB. For LDI/STI it runs two accesses, a pointer fetch followed by the data access. It drives the stall and load enables that freeze the MEM stage registers and advance them into WB.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: maximum cycles spent waiting in one access state before abort. Used only with LC3B_MEM_TIMEOUT_EN. Legal range 1–255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  MEM stage holds a valid instruction.
- mem_is_load  in  1  instruction reads data memory.
- mem_is_store  in  1  instruction writes data memory.
- mem_is_indirect  in  1  LDI/STI; pointer fetch required first.
- mem_is_byte  in  1  byte access (LDB/STB).
- mem_address  in  16  effective address from the MEM stage address register.
- dmem_rdata  in  16  read data from data memory.
- dmem_resp  in  1  memory completion strobe, valid for one cycle.
- dmem_read  out  1  read request.
- dmem_write  out  1  write request.
- dmem_address  out  16  word-aligned access address, with bit 0 always 0.
- dmem_byte_en  out  2  byte lanes: 2'b11 for word; 2'b01 or 2'b10 for byte, selected by address bit 0.
- pipe_stall  out  1  freeze upstream stages and the MEM stage registers.
- load_wb  out  1  load enable for the WB stage registers.
- mem_rdata_out  out  16  last completed load data, raw 16-bit word.
- timeout_err  out  1  one-cycle abort pulse. Tied 0 without the macro.

## Operation
- States: IDLE, IND, ACC, DONE.
- Transitions out of IDLE:
  - mem_valid & (mem_is_load | mem_is_store) & mem_is_indirect goes to IND.
  - mem_valid & (mem_is_load | mem_is_store) & ~mem_is_indirect goes to ACC.
  - Otherwise remain in IDLE.
- IND:
  - Drives dmem_read=1, dmem_address={mem_address[15:1],1'b0}, dmem_byte_en=2'b11.
  - On dmem_resp, latches dmem_rdata into a pointer register and goes to ACC.
- ACC:
  - Base address is the pointer register if indirect, else mem_address.
  - Drives dmem_address={base[15:1],1'b0}.
  - Drives dmem_read=mem_is_load and dmem_write=mem_is_store.
  - Drives dmem_byte_en per mem_is_byte and base[0]. Indirect accesses are always word accesses.
  - On dmem_resp, goes to DONE. For a load it also latches dmem_rdata into mem_rdata_out.
- DONE: unconditionally returns to IDLE after one cycle.
- Request outputs (dmem_read, dmem_write, dmem_address, dmem_byte_en) are Moore outputs and are stable for the whole of IND/ACC. They are 0 in IDLE and DONE.
- pipe_stall is 1 in IND and ACC. In IDLE it equals mem_valid & (mem_is_load | mem_is_store). It is 0 in DONE.
- load_wb = ~pipe_stall.
- The mem_* inputs are held stable by upstream while pipe_stall=1. They are sampled freely in every state.
- dmem_resp arriving in IDLE or DONE is ignored.
- mem_is_load and mem_is_store both set is illegal; load takes priority (no write issued).

## Timing
- Reset values: state IDLE, dmem_read=0, dmem_write=0, dmem_address=0, dmem_byte_en=0, mem_rdata_out=16'h0000, pointer=0, timeout_err=0, wait counter=0.
- Non-memory instruction: 0 stall cycles; load_wb=1 in the same cycle.
- Direct access with dmem_resp on the k-th ACC cycle (k≥1): pipe_stall high for 1+k cycles, then DONE with load_wb=1. mem_rdata_out is valid from DONE onward.
- Indirect access: stall = 1 + k_IND + k_ACC cycles.
- mem_rdata_out holds its value until the next completed load.
- Reset asserted in any state: the next edge forces IDLE and clears all registers. Outstanding memory requests are dropped with no completion, and the request outputs are 0 after that edge.

## Configuration
- LC3B_MEM_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entry to IND or ACC and increments each cycle without dmem_resp.
  - When the counter reaches TIMEOUT_CYCLES without a response, the block goes to DONE and timeout_err is 1 for that DONE cycle.
  - A load aborted this way writes mem_rdata_out=16'h0000. An aborted store is dropped. An aborted IND skips ACC.
- Not defined: the block waits indefinitely for dmem_resp, has no counter, and timeout_err is tied 0.

## Test plan
- Non-memory instruction (mem_valid=1, load=store=0) -> pipe_stall=0, load_wb=1 same cycle, dmem_read=dmem_write=0.
- LDR at mem_address=16'h3001, resp on 2nd ACC cycle with rdata 16'hBEEF -> dmem_read=1, dmem_address=16'h3000, byte_en=2'b11, stall 3 cycles, mem_rdata_out=16'hBEEF in DONE.
- STB at 16'h4005 -> dmem_write=1, dmem_address=16'h4004, byte_en=2'b10, no change to mem_rdata_out.
- LDI at 16'h2000 with pointer 16'h5002 and data 16'h1234, each resp on 1st cycle -> read 16'h2000, then read 16'h5002, 3 stall cycles, mem_rdata_out=16'h1234.
- Reset asserted during ACC of a pending load -> next cycle IDLE, dmem_read=0, mem_rdata_out=0, and a later dmem_resp is ignored.
- Macro on, TIMEOUT_CYCLES=4, LDR with no resp -> 4 cycles in ACC, then DONE with timeout_err=1 for one cycle, mem_rdata_out=16'h0000, then IDLE.
